// File: rtl/rc5_key_expand.sv
// RC5-32 key schedule: expands a KEY_WORDS x 32-bit key into T = 2*ROUNDS+2 subkeys,
// one table write per clock (T init steps, then 3*max(T,C) mixing steps).
module rc5_key_expand #(
  parameter int          ROUNDS    = 12,
  parameter int          KEY_WORDS = 4,
  parameter logic [31:0] P32       = 32'hB7E15163,
  parameter logic [31:0] Q32       = 32'h9E3779B9
) (
  input  logic                    clk,
  input  logic                    clr,
  input  logic [32*KEY_WORDS-1:0] key_in,
  input  logic                    key_ld,
  output logic                    busy,
  output logic                    key_rdy,
  input  logic [4:0]              skey_addr,
  output logic [31:0]             skey_dout
);

  localparam int T     = 2*ROUNDS + 2;
  localparam int MIX_N = 3 * ((T > KEY_WORDS) ? T : KEY_WORDS);
  localparam int IW    = $clog2(T);
  localparam int JW    = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int CW    = $clog2(MIX_N + 1);

  localparam logic [IW-1:0] I_LAST   = IW'(T - 1);
  localparam logic [JW-1:0] J_LAST   = JW'(KEY_WORDS - 1);
  localparam logic [CW-1:0] MIX_LAST = CW'(MIX_N - 1);

  typedef enum logic [1:0] {IDLE, INIT, MIX, DONE} state_t;

  state_t                        state_q, state_d;
  logic                          busy_q, busy_d;
  logic                          rdy_q, rdy_d;
  logic [31:0]                   dout_q, dout_d;
  logic [IW-1:0]                 i_q, i_d;
  logic [JW-1:0]                 j_q, j_d;
  logic [31:0]                   a_q, a_d;
  logic [31:0]                   b_q, b_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [31:0]                   val_q, val_d;
  logic [T-1:0][31:0]            s_q, s_d;
  logic [KEY_WORDS-1:0][31:0]    l_q, l_d;

  logic [31:0] a_new, b_new;

  // Rotate by doubling the word; an amount of 0 falls out naturally as identity.
  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] n);
    logic [63:0] t;
    t = {x, x} << n;
    return t[63:32];
  endfunction

  assign busy      = busy_q;
  assign key_rdy   = rdy_q;
  assign skey_dout = dout_q;

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    rdy_d   = rdy_q;
    i_d     = i_q;
    j_d     = j_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    s_d     = s_q;
    l_d     = l_q;

    a_new = rotl(s_q[i_q] + a_q + b_q, 5'd3);
    // (a_new + b)[4:0] only depends on the low five bits of each operand
    b_new = rotl(l_q[j_q] + a_new + b_q, a_new[4:0] + b_q[4:0]);

    dout_d = (int'(skey_addr) < T) ? s_q[skey_addr] : 32'h0;

    case (state_q)
      IDLE, DONE: begin
        if (key_ld) begin
          for (int k = 0; k < KEY_WORDS; k++) l_d[k] = key_in[32*k +: 32];
          i_d     = '0;
          val_d   = P32;
          busy_d  = 1'b1;
          rdy_d   = 1'b0;
          state_d = INIT;
        end
      end
      INIT: begin
        s_d[i_q] = val_q;
        val_d    = val_q + Q32;
        if (i_q == I_LAST) begin
          i_d     = '0;
          j_d     = '0;
          a_d     = '0;
          b_d     = '0;
          cnt_d   = '0;
          state_d = MIX;
        end else begin
          i_d = i_q + IW'(1);
        end
      end
      MIX: begin
        s_d[i_q] = a_new;
        l_d[j_q] = b_new;
        a_d      = a_new;
        b_d      = b_new;
        i_d      = (i_q == I_LAST) ? '0 : i_q + IW'(1);
        j_d      = (j_q == J_LAST) ? '0 : j_q + JW'(1);
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == MIX_LAST) begin
          busy_d  = 1'b0;
          rdy_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      dout_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      val_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      dout_q  <= dout_d;
      i_q     <= i_d;
      j_q     <= j_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
    end
  end

  // Table storage is not reset; contents are meaningless until key_rdy.
  always_ff @(posedge clk) begin
    s_q <= s_d;
    l_q <= l_d;
  end

endmodule

// File: tb/tb_rc5_key_expand.sv
// Bench for rc5_key_expand: C-style RC5 key-schedule model, per-cycle output compare,
// and the zero-key RC5 encrypt known answer to pin both the model and the DUT table.
module tb_rc5_key_expand;

  localparam int          T   = 26;
  localparam int          LAT = 104;
  localparam logic [31:0] P   = 32'hB7E15163;
  localparam logic [31:0] Q   = 32'h9E3779B9;

  logic         clk, clr, key_ld, busy, key_rdy;
  logic [127:0] key_in;
  logic [4:0]   skey_addr;
  logic [31:0]  skey_dout;

  rc5_key_expand dut (
    .clk(clk), .clr(clr), .key_in(key_in), .key_ld(key_ld), .busy(busy),
    .key_rdy(key_rdy), .skey_addr(skey_addr), .skey_dout(skey_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    int m;
    m = n & 31;
    if (m == 0) return x;
    return (x << m) | (x >> (32 - m));
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] exp_s [T];
  logic [31:0] dut_s [T];

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j;
    for (int c = 0; c < 4; c++) l[c] = k[32*c +: 32];
    exp_s[0] = P;
    for (int n = 1; n < T; n++) exp_s[n] = exp_s[n-1] + Q;
    a = 0; b = 0; i = 0; j = 0;
    for (int n = 0; n < 3*T; n++) begin
      a = rotl(exp_s[i] + a + b, 3);
      exp_s[i] = a;
      b = rotl(l[j] + a + b, int'(a + b));
      l[j] = b;
      i = (i + 1) % T;
      j = (j + 1) % 4;
    end
  endtask

  // RC5-32/12 encrypt of an all-zero block with either table.
  function automatic logic [63:0] enc0(input bit use_dut);
    logic [31:0] a, b, s [T];
    for (int n = 0; n < T; n++) s[n] = use_dut ? dut_s[n] : exp_s[n];
    a = s[0];
    b = s[1];
    for (int r = 1; r <= 12; r++) begin
      a = rotl(a ^ b, int'(b[4:0])) + s[2*r];
      b = rotl(b ^ a, int'(a[4:0])) + s[2*r+1];
    end
    return {a, b};
  endfunction

  // Timing model: everything follows from the cycle of the last accepted key_ld.
  int   cyc     = 0;
  int   ld_cyc  = -1;
  bit   started = 0;
  bit   clr_e   = 0;
  int   addr_e  = 0;

  always @(posedge clk) begin
    cyc++;
    clr_e  = clr;
    addr_e = int'(skey_addr);
    if (clr) begin
      started = 1;
      ld_cyc  = -1;
    end else if (key_ld && !(ld_cyc >= 0 && cyc - ld_cyc <= LAT)) begin
      ld_cyc = cyc;
      model_expand(key_in);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", {31'b0, busy}, {31'b0, (ld_cyc >= 0 && cyc - ld_cyc < LAT)});
      chk("key_rdy", {31'b0, key_rdy}, {31'b0, (ld_cyc >= 0 && cyc - ld_cyc >= LAT)});
      if (clr_e || addr_e >= T)
        chk("dout_zero", skey_dout, 32'h0);
      else if (ld_cyc >= 0 && cyc - ld_cyc > LAT)
        chk("dout", skey_dout, exp_s[addr_e]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    key_ld = 1'b1;
    @(negedge clk);
    key_ld = 1'b0;
    key_in = ~k;
  endtask

  // Called right after load(); counts edges from the accepting edge to key_rdy.
  task automatic wait_rdy(input int already);
    int n;
    n = already;
    while (!key_rdy && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rdy_latency", n, LAT);
  endtask

  task automatic read_all();
    skey_addr = 5'd0;
    for (int a = 0; a < 32; a++) begin
      @(negedge clk);
      if (a < T) dut_s[a] = skey_dout;
      skey_addr = 5'(a + 1);
    end
  endtask

  logic [127:0] k1, k2;

  initial begin
    clr = 1'b1; key_ld = 1'b0; key_in = '0; skey_addr = 5'd31;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'h0);
    chk("idle_rdy", {31'b0, key_rdy}, 32'h0);
    chk("idle_dout", skey_dout, 32'h0);

    // Zero key: known-answer ciphertext pins both model and DUT.
    load(128'h0);
    chk("busy_rise", {31'b0, busy}, 32'h1);
    wait_rdy(0);
    chk("busy_fall", {31'b0, busy}, 32'h0);
    read_all();
    chk("model_kat_a", enc0(1'b0) >> 32, 32'hEEDBA521);
    chk("model_kat_b", enc0(1'b0), 32'h6D8F4B15);
    chk("dut_kat_a", enc0(1'b1) >> 32, 32'hEEDBA521);
    chk("dut_kat_b", enc0(1'b1), 32'h6D8F4B15);
    chk("init_s0_const", P + 32'd25 * Q, 32'hB7E15163 + 32'd25 * 32'h9E3779B9);

    // Random keys (reload from DONE each time).
    for (int r = 0; r < 20; r++) begin
      load({$urandom, $urandom, $urandom, $urandom});
      chk("reload_rdy_drop", {31'b0, key_rdy}, 32'h0);
      wait_rdy(0);
      read_all();
    end

    // Busy protection: second key at cycle 50 is ignored.
    k1 = {$urandom, $urandom, $urandom, $urandom};
    k2 = ~k1;
    load(k1);
    repeat (49) @(negedge clk);
    key_in = k2; key_ld = 1'b1;
    @(negedge clk);
    key_ld = 1'b0;
    wait_rdy(50);
    read_all();

    // Mid-expansion reset, then a clean reload.
    load({$urandom, $urandom, $urandom, $urandom});
    repeat (59) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("clr_busy", {31'b0, busy}, 32'h0);
    chk("clr_rdy", {31'b0, key_rdy}, 32'h0);
    chk("clr_dout", skey_dout, 32'h0);
    repeat (3) @(negedge clk);
    load(128'h0123456789ABCDEF_FEDCBA9876543210);
    wait_rdy(0);
    read_all();
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
